button_conditioner: RTL and testbench



---
 rtl/button_pkg.sv | 18 +
 rtl/sync_2ff.sv | 29 ++
 rtl/button_conditioner.sv | 157 +++++++++++++++
 tb/tb_button_conditioner.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// button_pkg
// Shared types and helpers for the push-button conditioner.
//   state_t   : conditioner FSM state encoding (2 bits)
//   cnt_width : bits needed to hold counts 0..n
package button_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_DEB = 2'd1,
        HELD      = 2'd2,
        REL_DEB   = 2'd3
    } state_t;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
// Two-flop synchroniser for an asynchronous pad input into the clk domain.
// Ports:
//   clk   : destination clock
//   rst_n : asynchronous active-low reset; both flops load RESET_VAL
//   d     : asynchronous input
//   q     : synchronised output (two clk cycles of latency)
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner
// Turns a raw, bouncing push-button pin into a clean debounced level plus
// single-cycle press / release / long-press strobes.
// Build option: define BUTTON_LONG_PRESS_EN to generate the long-press
// counter and long_pulse; otherwise long_pulse is tied 0 and LONG_CYCLES
// has no effect.
// Ports:
//   clk           : system clock
//   rst_n         : asynchronous active-low reset
//   btn_raw       : asynchronous pad input
//   btn_level     : debounced pressed state, 1 = pressed
//   press_pulse   : one-cycle strobe on accepted press
//   release_pulse : one-cycle strobe on accepted release
//   long_pulse    : one-cycle strobe once per press held LONG_CYCLES
//
// state     | meaning
// IDLE      | released and stable
// PRESS_DEB | pressed level seen, counting stable cycles
// HELD      | press accepted, btn_level = 1
// REL_DEB   | released level seen while held, counting stable cycles
module button_conditioner
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES     = 100_000_000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam int             DW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0]  D_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    // Pin level when the button is not pressed.
    localparam logic           PIN_IDLE = (ACTIVE_LOW != 0);

    logic          pin_sync;
    logic          s;
    logic          held_entry;
    state_t        state;
    logic [DW-1:0] dcnt;

    sync_2ff #(.RESET_VAL(PIN_IDLE)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (btn_raw),
        .q     (pin_sync)
    );

    assign s          = pin_sync ^ PIN_IDLE;
    assign held_entry = (state == PRESS_DEB) && s && (dcnt == D_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            dcnt          <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (s) begin
                        state <= PRESS_DEB;
                        dcnt  <= '0;
                    end
                end
                PRESS_DEB: begin
                    if (!s) begin
                        state <= IDLE;
                        dcnt  <= '0;
                    end else if (dcnt == D_LAST) begin
                        state       <= HELD;
                        dcnt        <= '0;
                        press_pulse <= 1'b1;
                        btn_level   <= 1'b1;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!s) begin
                        state <= REL_DEB;
                        dcnt  <= '0;
                    end
                end
                REL_DEB: begin
                    if (s) begin
                        state <= HELD;
                        dcnt  <= '0;
                    end else if (dcnt == D_LAST) begin
                        state         <= IDLE;
                        dcnt          <= '0;
                        release_pulse <= 1'b1;
                        btn_level     <= 1'b0;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    dcnt  <= '0;
                end
            endcase
        end
    end

`ifdef BUTTON_LONG_PRESS_EN
    localparam int            LW     = cnt_width(LONG_CYCLES);
    localparam logic [LW-1:0] L_LAST = LW'(LONG_CYCLES - 1);

    logic [LW-1:0] lcnt;
    logic          long_fired;

    // lcnt only advances in HELD, so a release bounce freezes it and the
    // count resumes where it left off. long_fired keeps the saturated count
    // from re-triggering until the next accepted press clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lcnt       <= '0;
            long_fired <= 1'b0;
            long_pulse <= 1'b0;
        end else begin
            long_pulse <= (lcnt == L_LAST) && !long_fired;
            if (held_entry) begin
                lcnt       <= '0;
                long_fired <= 1'b0;
            end else begin
                if (lcnt == L_LAST) begin
                    long_fired <= 1'b1;
                end
                if ((state == HELD) && s && (lcnt != L_LAST)) begin
                    lcnt <= lcnt + 1'b1;
                end
            end
        end
    end
`else
    assign long_pulse = 1'b0;

    // LONG_CYCLES only matters when the long-press counter is built; this
    // empty block just keeps the parameter referenced in this build.
    if (LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_long_cycles_unused
    end

    logic unused_held_entry;
    assign unused_held_entry = held_entry;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

`ifdef BUTTON_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic btn_raw;
    logic btn_raw_hi;
    logic btn_level, press_pulse, release_pulse, long_pulse;
    logic hi_level, hi_press, hi_release, hi_long;

    int tests = 0;
    int fails = 0;

    button_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .LONG_CYCLES     (16),
        .ACTIVE_LOW      (1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_raw       (btn_raw),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse)
    );

    button_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .LONG_CYCLES     (16),
        .ACTIVE_LOW      (0)
    ) dut_hi (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_raw       (btn_raw_hi),
        .btn_level     (hi_level),
        .press_pulse   (hi_press),
        .release_pulse (hi_release),
        .long_pulse    (hi_long)
    );

    // Expected outputs are packed {btn_level, press, release, long}.
    typedef struct {
        logic       raw;
        logic [3:0] exp;
    } vec_t;

    vec_t vt [1:52];

    function automatic logic [3:0] outs();
        return {btn_level, press_pulse, release_pulse, long_pulse};
    endfunction

    function automatic logic [3:0] outs_hi();
        return {hi_level, hi_press, hi_release, hi_long};
    endfunction

    function automatic logic [3:0] mk(input bit lvl, input bit p, input bit r, input bit l);
        return {lvl, p, r, l};
    endfunction

    task automatic check(input string name, input int idx, input logic [3:0] got, input logic [3:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s[%0d]: got lvl/prs/rel/lng=%b expected %b", name, idx, got, exp);
        end
    endtask

    // Drive the main pin from the low phase, run one rising edge, return at
    // the next falling edge where registered outputs are stable.
    task automatic cyc(input logic raw);
        btn_raw = raw;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Hold pressed from IDLE: press at edge 7, long (if built) at edge 23.
    task automatic press_seq(input string name, input int n);
        for (int k = 1; k <= n; k++) begin
            cyc(1'b0);
            check(name, k, outs(), mk(k >= 7, k == 7, 1'b0, LONG_EN && (k == 23)));
        end
    endtask

    // Release from HELD: release strobe and level drop at edge 7.
    task automatic release_seq(input string name, input int n);
        for (int k = 1; k <= n; k++) begin
            cyc(1'b1);
            check(name, k, outs(), mk(k < 7, 1'b0, k == 7, 1'b0));
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        btn_raw    = 1'b1;
        btn_raw_hi = 1'b0;

        for (int k = 1; k <= 52; k++) begin
            vt[k].raw = (k <= 40) ? 1'b0 : 1'b1;
            vt[k].exp = mk((k >= 7) && (k < 47), k == 7, k == 47, LONG_EN && (k == 23));
        end

        repeat (3) @(negedge clk);
        check("reset_main", 0, outs(), 4'b0000);
        check("reset_hi", 0, outs_hi(), 4'b0000);
        rst_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            cyc(1'b1);
            check("idle", k, outs(), 4'b0000);
        end

        // Clean press held 40 cycles then clean release.
        for (int k = 1; k <= 52; k++) begin
            cyc(vt[k].raw);
            check("clean", k, outs(), vt[k].exp);
        end

        // Bounce: pressed 3 samples, released 1, then stable pressed from
        // edge 5, so the press lands on edge 11.
        for (int k = 1; k <= 12; k++) begin
            cyc((k == 4) ? 1'b1 : 1'b0);
            check("bounce", k, outs(), mk(k >= 11, k == 11, 1'b0, 1'b0));
        end
        release_seq("bounce_rel", 10);

        // Release glitch after the long strobe: no release, no repeat.
        press_seq("glitch_press", 30);
        for (int k = 31; k <= 44; k++) begin
            cyc((k == 31 || k == 32) ? 1'b1 : 1'b0);
            check("glitch", k, outs(), mk(1'b1, 1'b0, 1'b0, 1'b0));
        end
        release_seq("glitch_rel", 10);

        // Reset while HELD clears outputs asynchronously; held button is
        // debounced again from scratch afterwards.
        press_seq("rst_held_press", 9);
        #2 rst_n = 1'b0;
        #1 check("rst_held_async", 0, outs(), 4'b0000);
        @(negedge clk);
        check("rst_held_low", 0, outs(), 4'b0000);
        rst_n = 1'b1;
        press_seq("rst_held_again", 8);
        release_seq("rst_held_rel", 10);

        // Reset in PRESS_DEB with dcnt at 2 (after edge 5).
        for (int k = 1; k <= 5; k++) begin
            cyc(1'b0);
            check("rst_deb_pre", k, outs(), 4'b0000);
        end
        #2 rst_n = 1'b0;
        #1 check("rst_deb_async", 0, outs(), 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        press_seq("rst_deb_again", 8);
        release_seq("rst_deb_rel", 10);

        // Active-high instance: single-cycle raw pulse is ignored.
        btn_raw_hi = 1'b1;
        cyc(1'b1);
        check("hi_glitch", 0, outs_hi(), 4'b0000);
        btn_raw_hi = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            cyc(1'b1);
            check("hi_glitch", k, outs_hi(), 4'b0000);
        end

        // Active-high instance: held high is a press, low is a release.
        btn_raw_hi = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            cyc(1'b1);
            check("hi_press", k, outs_hi(), mk(k >= 7, k == 7, 1'b0, 1'b0));
        end
        btn_raw_hi = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            cyc(1'b1);
            check("hi_rel", k, outs_hi(), mk(k < 7, 1'b0, k == 7, 1'b0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
